// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the multiplexed 7-segment scan driver: control, write port,
// per-digit masks and the pin-level display outputs.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  ena;
  logic                  wr_en;
  logic [2:0]            wr_addr;
  logic [4:0]            wr_data;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] digit_sel;

  // Controller side: drives control/write/masks, observes the display pins.
  modport master (
    output ena, wr_en, wr_addr, wr_data, blank_mask, blink_mask,
    input  seg, dp, digit_sel
  );

  // Driver side: consumes control/write/masks, drives the display pins.
  modport slave (
    input  ena, wr_en, wr_addr, wr_data, blank_mask, blink_mask,
    output seg, dp, digit_sel
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver: digit store, refresh prescaler,
// scan index, blink timer and registered, optionally inverted, outputs.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 64,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam logic [15:0] PRE_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]  BLK_LAST = 8'(BLINK_DIV - 1);
  localparam logic        INV      = (ACTIVE_LOW != 0);

  logic [4:0]            r_store [NUM_DIGITS];
  logic [15:0]           r_presc;
  logic [2:0]            r_idx;
  logic [7:0]            r_blk_cnt;
  logic                  r_blink_phase;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_sel;

  logic                  w_presc_tc;
  logic                  w_scan_wrap;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [4:0]            w_cur;
  logic [6:0]            w_seg_dec;
  logic                  w_off;

  assign w_presc_tc  = (r_presc == PRE_LAST);
  assign w_scan_wrap = w_presc_tc && (r_idx == IDX_LAST);

  // One-hot view of the scan index; compared per digit so out-of-range
  // index bits can never select anything.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
    assign w_onehot[gi] = (r_idx == 3'(gi));
  end

  // Digit store: an address past the last digit matches no entry and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_store[i] <= '0;
    end else if (bus.ena && bus.wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.wr_addr == 3'(i)) r_store[i] <= bus.wr_data;
      end
    end
  end

  // Prescaler, scan index and blink timer; all frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_blk_cnt     <= '0;
      r_blink_phase <= 1'b0;
    end else if (bus.ena) begin
      if (w_presc_tc) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        if (w_scan_wrap) begin
          if (r_blk_cnt == BLK_LAST) begin
            r_blk_cnt     <= '0;
            r_blink_phase <= ~r_blink_phase;
          end else begin
            r_blk_cnt <= r_blk_cnt + 8'd1;
          end
        end
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

  // Read mux: pick the store entry of the currently selected digit.
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_onehot[i]) w_cur = r_store[i];
    end
  end

  // Hex to segment decode, bit 0 = a ... bit 6 = g, logical active-high.
  always_comb begin
    w_seg_dec = 7'h00;
    case (w_cur[3:0])
      4'h0: w_seg_dec = 7'h3F;
      4'h1: w_seg_dec = 7'h06;
      4'h2: w_seg_dec = 7'h5B;
      4'h3: w_seg_dec = 7'h4F;
      4'h4: w_seg_dec = 7'h66;
      4'h5: w_seg_dec = 7'h6D;
      4'h6: w_seg_dec = 7'h7D;
      4'h7: w_seg_dec = 7'h07;
      4'h8: w_seg_dec = 7'h7F;
      4'h9: w_seg_dec = 7'h6F;
      4'hA: w_seg_dec = 7'h77;
      4'hB: w_seg_dec = 7'h7C;
      4'hC: w_seg_dec = 7'h39;
      4'hD: w_seg_dec = 7'h5E;
      4'hE: w_seg_dec = 7'h79;
      4'hF: w_seg_dec = 7'h71;
    endcase
  end

  // Selected digit goes dark when blanked, or when blinking in the off phase.
  assign w_off = (|(w_onehot & bus.blank_mask)) ||
                 (r_blink_phase && (|(w_onehot & bus.blink_mask)));

  // Registered outputs; digit_sel keeps scanning while segments are dark so
  // every digit gets the same duty cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_dp  <= 1'b0;
      r_sel <= '0;
    end else if (!bus.ena) begin
      r_seg <= '0;
      r_dp  <= 1'b0;
      r_sel <= '0;
    end else begin
      r_sel <= w_onehot;
      r_seg <= w_off ? 7'h00 : w_seg_dec;
      r_dp  <= w_off ? 1'b0 : w_cur[4];
    end
  end

  // Pin polarity is applied last so "off" is all-ones on active-low boards.
  assign bus.seg       = r_seg ^ {7{INV}};
  assign bus.dp        = r_dp ^ INV;
  assign bus.digit_sel = r_sel ^ {NUM_DIGITS{INV}};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: an active-high and an active-low
// instance share stimulus; expected logical values are hand-computed and the
// active-low pins are checked as their bitwise complement.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  localparam logic [6:0] DEC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus1 ();

  assign bus1.ena        = bus0.ena;
  assign bus1.wr_en      = bus0.wr_en;
  assign bus1.wr_addr    = bus0.wr_addr;
  assign bus1.wr_data    = bus0.wr_data;
  assign bus1.blank_mask = bus0.blank_mask;
  assign bus1.blink_mask = bus0.blink_mask;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(0)
  ) u_dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1)
  ) u_dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic       ena;
    logic       wr_en;
    logic [2:0] addr;
    logic [4:0] data;
    logic [3:0] blank;
    logic [3:0] blink;
    int         ncyc;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic we, logic [2:0] a, logic [4:0] d,
                              logic [3:0] bl, logic [3:0] bk, int n,
                              logic [3:0] s, logic [6:0] sg, logic p);
    vec_t v;
    v.ena = en; v.wr_en = we; v.addr = a; v.data = d;
    v.blank = bl; v.blink = bk; v.ncyc = n;
    v.sel = s; v.seg = sg; v.dp = p;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Check both instances against one logical expectation.
  task automatic chk_out(input string tag, input logic [3:0] sel,
                         input logic [6:0] seg, input logic dp);
    logic [6:0] seg_n;
    logic [3:0] sel_n;
    seg_n = ~seg;
    sel_n = ~sel;
    chk({tag, " seg"},     {1'b0, bus0.seg},       {1'b0, seg});
    chk({tag, " dp"},      {7'b0, bus0.dp},        {7'b0, dp});
    chk({tag, " sel"},     {4'b0, bus0.digit_sel}, {4'b0, sel});
    chk({tag, " seg_pin"}, {1'b0, bus1.seg},       {1'b0, seg_n});
    chk({tag, " dp_pin"},  {7'b0, bus1.dp},        {7'b0, ~dp});
    chk({tag, " sel_pin"}, {4'b0, bus1.digit_sel}, {4'b0, sel_n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh;
    int d;

    bus0.ena = 1'b0; bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus0.blank_mask = '0; bus0.blink_mask = '0;

    // Reset state: logical zero, active-low pins all ones.
    tick();
    tick();
    chk_out("reset", 4'b0000, 7'h00, 1'b0);
    $display("reset: seg=%h dp=%b sel=%b | pins seg=%h dp=%b sel=%b",
             bus0.seg, bus0.dp, bus0.digit_sel, bus1.seg, bus1.dp, bus1.digit_sel);
    rst_n = 1'b1;

    // Writes of 1..4, then scanning with digit 1 blinking, then addr-5 write
    // and digit 3 blanked.
    vecs.push_back(mk(1, 1, 3'd0, 5'h01, 4'h0, 4'b0010, 1, 4'b0001, 7'h3F, 0));
    vecs.push_back(mk(1, 1, 3'd1, 5'h02, 4'h0, 4'b0010, 1, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 1, 3'd2, 5'h03, 4'h0, 4'b0010, 1, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 1, 3'd3, 5'h04, 4'h0, 4'b0010, 1, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0010, 7'h5B, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0100, 7'h4F, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b1000, 7'h66, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0010, 7'h5B, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0100, 7'h4F, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b1000, 7'h66, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0010, 7'h00, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0100, 7'h4F, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b1000, 7'h66, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0010, 7'h00, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0100, 7'h4F, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b1000, 7'h66, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'b0010, 4, 4'b0010, 7'h5B, 0));
    vecs.push_back(mk(1, 1, 3'd5, 5'h00, 4'b1000, 4'h0, 4, 4'b0100, 7'h4F, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'b1000, 4'h0, 4, 4'b1000, 7'h00, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'h0, 4, 4'b0001, 7'h06, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'h0, 4, 4'b0010, 7'h5B, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'h0, 4, 4'b0100, 7'h4F, 0));
    vecs.push_back(mk(1, 0, 3'd0, 5'h00, 4'h0, 4'h0, 4, 4'b1000, 7'h66, 0));

    foreach (vecs[i]) begin
      bus0.ena        = vecs[i].ena;
      bus0.wr_en      = vecs[i].wr_en;
      bus0.wr_addr    = vecs[i].addr;
      bus0.wr_data    = vecs[i].data;
      bus0.blank_mask = vecs[i].blank;
      bus0.blink_mask = vecs[i].blink;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        tick();
        chk_out($sformatf("vec%0d.%0d", i, c), vecs[i].sel, vecs[i].seg, vecs[i].dp);
      end
      $display("vec %0d: sel=%b seg=%h dp=%b (expected sel=%b seg=%h dp=%b)",
               i, bus0.digit_sel, bus0.seg, bus0.dp, vecs[i].sel, vecs[i].seg, vecs[i].dp);
    end
    bus0.wr_en = 1'b0;

    // Writes to the selected digit show up one cycle later without a scan hiccup.
    bus0.wr_en = 1'b1; bus0.wr_addr = 3'd0; bus0.wr_data = 5'h08;
    tick();
    chk_out("live_wr0", 4'b0001, 7'h06, 1'b0);
    bus0.wr_data = 5'h1E;
    tick();
    chk_out("live_wr1", 4'b0001, 7'h7F, 1'b0);
    bus0.wr_en = 1'b0;
    tick();
    chk_out("live_wr2", 4'b0001, 7'h79, 1'b1);
    tick();
    chk_out("live_wr3", 4'b0001, 7'h79, 1'b1);
    $display("live write: seg=%h dp=%b sel=%b", bus0.seg, bus0.dp, bus0.digit_sel);

    // Decode sweep: each value written into the digit just coming up.
    for (int k = 0; k < 16; k++) begin
      d  = (1 + k) % 4;
      oh = 4'b0001 << d;
      bus0.wr_en = 1'b1; bus0.wr_addr = 3'(d); bus0.wr_data = 5'(k);
      tick();
      chk($sformatf("sweep%0d sel", k), {4'b0, bus0.digit_sel}, {4'b0, oh});
      bus0.wr_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick();
        chk_out($sformatf("sweep%0d.%0d", k, c), oh, DEC[k], 1'b0);
      end
      $display("decode %h: seg=%h sel=%b", k[3:0], bus0.seg, bus0.digit_sel);
    end

    // ena low mid-digit: dark outputs, state and store frozen, then resume.
    tick();
    chk_out("pre_hold0", 4'b0010, 7'h39, 1'b0);
    tick();
    chk_out("pre_hold1", 4'b0010, 7'h39, 1'b0);
    bus0.ena = 1'b0; bus0.wr_en = 1'b1; bus0.wr_addr = 3'd1; bus0.wr_data = 5'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("hold%0d", c), 4'b0000, 7'h00, 1'b0);
    end
    $display("hold: seg=%h sel=%b pins sel=%b", bus0.seg, bus0.digit_sel, bus1.digit_sel);
    bus0.ena = 1'b1; bus0.wr_en = 1'b0;
    tick();
    chk_out("resume0", 4'b0010, 7'h39, 1'b0);
    tick();
    chk_out("resume1", 4'b0010, 7'h39, 1'b0);
    tick();
    chk_out("resume2", 4'b0100, 7'h5E, 1'b0);
    $display("resume: seg=%h sel=%b", bus0.seg, bus0.digit_sel);

    // Reset pulse mid-scan: outputs go dark at once, store and scan restart.
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 4'b0000, 7'h00, 1'b0);
    tick();
    chk_out("rst_held", 4'b0000, 7'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("post_rst0", 4'b0001, 7'h3F, 1'b0);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk_out($sformatf("post_rst%0d", c), 4'b0001, 7'h3F, 1'b0);
    end
    tick();
    chk_out("post_rst_d1", 4'b0010, 7'h3F, 1'b0);
    $display("post reset: seg=%h sel=%b pins seg=%h sel=%b",
             bus0.seg, bus0.digit_sel, bus1.seg, bus1.digit_sel);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1-8.
REQ-002 SHALL have parameter REFRESH_DIV, default 1000, clk cycles each digit stays selected, legal range 2-65535.
REQ-003 SHALL have parameter BLINK_DIV, default 64, full scans per blink half-period, legal range 1-255.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts seg, dp and digit_sel at the outputs.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ena  input  1  design enable; low freezes scanning and blanks the display.
REQ-008 SHALL have port wr_en  input  1  write strobe for the digit store.
REQ-009 SHALL have port wr_addr  input  3  digit index to write.
REQ-010 SHALL have port wr_data  input  5  [3:0] hex value, [4] decimal point.
REQ-011 SHALL have port blank_mask  input  NUM_DIGITS  per-digit force-off.
REQ-012 SHALL have port blink_mask  input  NUM_DIGITS  per-digit blink enable.
REQ-013 SHALL have port seg  output  7  segments, seg[0]=a ... seg[6]=g.
REQ-014 SHALL have port dp  output  1  decimal point.
REQ-015 SHALL have port digit_sel  output  NUM_DIGITS  one-hot digit enable.

Function
REQ-016 SHALL hold a NUM_DIGITS x 5-bit digit store; write occurs on a clk edge with ena=1, wr_en=1 and wr_addr<NUM_DIGITS; wr_addr>=NUM_DIGITS is ignored with no side effect.
REQ-017 SHALL run a prescaler counting 0..REFRESH_DIV-1 while ena=1; at terminal count it returns to 0 and the scan index advances by one.
REQ-018 SHALL wrap the scan index from NUM_DIGITS-1 to 0; each wrap is one full scan.
REQ-019 SHALL count full scans modulo BLINK_DIV and toggle blink_phase on each count of BLINK_DIV scans.
REQ-020 SHALL register all outputs: seg, dp and digit_sel reflect scan index, store contents and masks sampled on the previous clk edge (one-cycle latency).
REQ-021 SHALL make a write to the currently selected digit visible on seg/dp one cycle after the write edge, with no scan disturbance.
REQ-022 SHALL decode hex per: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F A=0x77 b=0x7C C=0x39 d=0x5E E=0x79 F=0x71 (bit order a..g, active-high logical).
REQ-023 SHALL drive digit_sel one-hot at the scan index even when the digit is blanked, keeping per-digit duty cycle constant.
REQ-024 SHALL force seg=0 and dp=0 (logical) for the selected digit when its blank_mask bit is 1, or when its blink_mask bit is 1 and blink_phase=1.
REQ-025 SHALL, with ena=0, hold prescaler, scan index, blink counter and blink_phase, ignore writes, and drive seg, dp, digit_sel logically all-zero from the next edge.
REQ-026 SHALL resume scanning from the held state on the first edge with ena=1.
REQ-027 SHALL apply ACTIVE_LOW inversion after all logic, so "off" is all-ones on the pins when ACTIVE_LOW=1.
REQ-028 SHALL with NUM_DIGITS=1 keep the index at 0 and count a full scan at every prescaler terminal count.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear digit store, prescaler, scan index, blink counter and blink_phase to 0.
REQ-030 SHALL, during reset, drive seg=0, dp=0, digit_sel=0 logical (pins inverted when ACTIVE_LOW=1).
REQ-031 SHALL, after rst_n release mid-operation, restart from index 0 with digit_sel=0b0001 (logical) on the first edge with ena=1.

Verification
REQ-032 Decode: NUM_DIGITS=4, REFRESH_DIV=4, write 0x8 to addr 0, ena=1 -> while digit_sel=0001, seg=0x7F, dp=0.
REQ-033 Scan: write 1,2,3,4 to addr 0-3 -> digit_sel sequence 0001,0010,0100,1000,0001 each for 4 cycles; seg 0x06,0x5B,0x4F,0x66.
REQ-034 Blink: BLINK_DIV=2, blink_mask=0010 -> digit 1 seg alternates 0x5B / 0x00 every 2 full scans (32 cycles); other digits unaffected.
REQ-035 Boundaries: write to addr 5 -> store unchanged; blank_mask=1000 -> digit 3 seg=0, digit_sel still 1000 for 4 cycles.
REQ-036 ena/reset: ena=0 mid-digit -> outputs 0 next edge, index held; ena=1 resumes same digit and remaining count; rst_n pulse mid-scan -> outputs 0 immediately, store cleared.
REQ-037 Polarity: ACTIVE_LOW=1, digit 0 = 0x0 -> seg pins=0x40, digit_sel pins=1110; reset -> all pins 1.
